// File: rtl/layer_sequencer_if.sv
// Handshake bundle between the training controller, the layer chain
// and the layer sequencer.
interface layer_sequencer_if #(
   parameter int NUM_LAYERS = 4,
   parameter int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
);
   logic                  start;
   logic                  train;
   logic                  abort;
   logic [NUM_LAYERS-1:0] fd_prop_done;
   logic [NUM_LAYERS-1:0] bk_prop_done;
   logic [NUM_LAYERS-1:0] fd_prop;
   logic [NUM_LAYERS-1:0] bk_prop;
   logic                  busy;
   logic                  done;
   logic                  error;
   logic [IDX_W-1:0]      layer_idx;
   logic                  bk_phase;

   modport master (
      output start, train, abort, fd_prop_done, bk_prop_done,
      input  fd_prop, bk_prop, busy, done, error, layer_idx, bk_phase
   );

   modport slave (
      input  start, train, abort, fd_prop_done, bk_prop_done,
      output fd_prop, bk_prop, busy, done, error, layer_idx, bk_phase
   );
endinterface

// File: rtl/layer_sequencer.sv
// Forward/backward pass sequencer for a chain of trit layers with a
// per-layer timeout watchdog.
module layer_sequencer #(
   parameter int NUM_LAYERS = 4,
   parameter int TIMEOUT = 255,
   parameter int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
   input logic clk_in,
   input logic rst_in,
   layer_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      FWD_ISSUE,
      FWD_WAIT,
      BK_ISSUE,
      BK_WAIT,
      FINISH
   } state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_LAYERS - 1);
   localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

   state_t                state;
   logic [15:0]           cnt;
   logic                  train_q;
   logic [IDX_W-1:0]      idx;
   logic [NUM_LAYERS-1:0] fd_q;
   logic [NUM_LAYERS-1:0] bk_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  err_q;
   logic                  bkp_q;
   logic                  fd_hit;
   logic                  bk_hit;
   logic                  tmo;

   function automatic logic [NUM_LAYERS-1:0] onehot(
      input logic [IDX_W-1:0] i
   );
      logic [NUM_LAYERS-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   assign fd_hit = bus.fd_prop_done[idx];
   assign bk_hit = bus.bk_prop_done[idx];
   assign tmo    = (cnt == TMAX);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state   <= IDLE;
         cnt     <= '0;
         train_q <= 1'b0;
         idx     <= '0;
         fd_q    <= '0;
         bk_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         bkp_q   <= 1'b0;
      end else begin
         fd_q   <= '0;
         bk_q   <= '0;
         done_q <= 1'b0;
         // abort outranks any done or timeout seen this cycle
         if (bus.abort && state != IDLE) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            bkp_q  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (bus.start && !bus.abort) begin
                     train_q <= bus.train;
                     err_q   <= 1'b0;
                     idx     <= '0;
                     busy_q  <= 1'b1;
                     fd_q    <= onehot('0);
                     state   <= FWD_ISSUE;
                  end
               end
               FWD_ISSUE: begin
                  cnt   <= '0;
                  state <= FWD_WAIT;
               end
               FWD_WAIT: begin
                  if (fd_hit) begin
                     if (idx != LAST) begin
                        idx   <= idx + 1'b1;
                        fd_q  <= onehot(idx + 1'b1);
                        state <= FWD_ISSUE;
                     end else if (train_q) begin
                        bk_q  <= onehot(idx);
                        bkp_q <= 1'b1;
                        state <= BK_ISSUE;
                     end else begin
                        done_q <= 1'b1;
                        state  <= FINISH;
                     end
                  end else if (tmo) begin
                     err_q  <= 1'b1;
                     done_q <= 1'b1;
                     state  <= FINISH;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               BK_ISSUE: begin
                  cnt   <= '0;
                  state <= BK_WAIT;
               end
               BK_WAIT: begin
                  if (bk_hit) begin
                     if (idx != '0) begin
                        idx   <= idx - 1'b1;
                        bk_q  <= onehot(idx - 1'b1);
                        state <= BK_ISSUE;
                     end else begin
                        done_q <= 1'b1;
                        bkp_q  <= 1'b0;
                        state  <= FINISH;
                     end
                  end else if (tmo) begin
                     err_q  <= 1'b1;
                     done_q <= 1'b1;
                     bkp_q  <= 1'b0;
                     state  <= FINISH;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               FINISH: begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.fd_prop   = fd_q;
   assign bus.bk_prop   = bk_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.error     = err_q;
   assign bus.layer_idx = idx;
   assign bus.bk_phase  = bkp_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: four responding layers, directed
// passes, timeout, early/wrong done, abort, reset and ignored start.
module tb_layer_sequencer;

   typedef struct packed {
      int         cyc;
      logic [3:0] fd;
      logic [3:0] bk;
      logic       dn;
      logic       err;
      logic [1:0] idx;
      logic       bkp;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   ev_t  q[$];

   logic [3:0] resp_fd = '0;
   logic [3:0] resp_bk = '0;
   logic [3:0] inj_fd = '0;
   logic [3:0] fmute = '0;
   logic       inj_en = 1'b0;
   int         fcnt[4];
   int         bcnt[4];

   layer_sequencer_if #(.NUM_LAYERS(4), .IDX_W(2)) bus ();

   layer_sequencer #(.NUM_LAYERS(4), .TIMEOUT(8)) dut (
      .clk_in(clk),
      .rst_in(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign bus.fd_prop_done = resp_fd | inj_fd;
   assign bus.bk_prop_done = resp_bk;

   // layers answer 3 cycles after their prop pulse
   always @(negedge clk) begin
      resp_fd = '0;
      resp_bk = '0;
      inj_fd  = '0;
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            fcnt[i] = 0;
            bcnt[i] = 0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (fcnt[i] > 0) begin
               fcnt[i]--;
               if (fcnt[i] == 0) resp_fd[i] = 1'b1;
            end
            if (bcnt[i] > 0) begin
               bcnt[i]--;
               if (bcnt[i] == 0) resp_bk[i] = 1'b1;
            end
            if (bus.fd_prop[i] && !fmute[i]) fcnt[i] = 3;
            if (bus.bk_prop[i]) bcnt[i] = 3;
         end
         if (inj_en) begin
            if (bus.fd_prop != 4'b0000) inj_fd = 4'b1111;
            else if (bus.busy && bus.layer_idx == 2'd1)
               inj_fd = 4'b1000;
         end
      end
   end

   always @(negedge clk) begin
      ev_t act;
      ev_t e;
      if (rst_n && (bus.fd_prop != 0 || bus.bk_prop != 0 || bus.done)) begin
         act = '{cyc, bus.fd_prop, bus.bk_prop, bus.done,
                 bus.error, bus.layer_idx, bus.bk_phase};
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d fd=%b bk=%b done=%b",
                     cyc, bus.fd_prop, bus.bk_prop, bus.done);
         end else begin
            e = q.pop_front();
            if (act !== e) begin
               errors++;
               $display({"FAIL event got cyc=%0d fd=%b bk=%b dn=%b err=%b",
                         " idx=%0d bkp=%b expected cyc=%0d fd=%b bk=%b",
                         " dn=%b err=%b idx=%0d bkp=%b"},
                        act.cyc, act.fd, act.bk, act.dn, act.err,
                        act.idx, act.bkp, e.cyc, e.fd, e.bk, e.dn,
                        e.err, e.idx, e.bkp);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, want);
      end
   endtask

   task automatic push(input int c, input logic [3:0] fd,
                       input logic [3:0] bk, input logic dn,
                       input logic err, input logic [1:0] idx,
                       input logic bkp);
      q.push_back('{c, fd, bk, dn, err, idx, bkp});
   endtask

   task automatic push_fwd(input int t0, input int n);
      logic [3:0] one;
      one = 4'b0001;
      for (int i = 0; i < n; i++)
         push(t0 + 1 + 4 * i, one << i, 4'b0, 1'b0, 1'b0, i[1:0], 1'b0);
   endtask

   task automatic push_bk(input int t0, input int n);
      logic [3:0] one;
      int         l;
      one = 4'b0001;
      for (int k = 0; k < n; k++) begin
         l = 3 - k;
         push(t0 + 17 + 4 * k, 4'b0, one << l, 1'b0, 1'b0, l[1:0], 1'b1);
      end
   endtask

   task automatic sync(output int t0);
      @(negedge clk);
      t0 = cyc;
   endtask

   task automatic pulse(input logic tr);
      bus.start = 1'b1;
      bus.train = tr;
      @(negedge clk);
      bus.start = 1'b0;
      bus.train = 1'b0;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic end_check(input string name);
      chk(name, q.size(), 0);
      q.delete();
   endtask

   function automatic logic [31:0] outs();
      return {18'd0, bus.fd_prop, bus.bk_prop, bus.busy, bus.done,
              bus.error, bus.layer_idx, bus.bk_phase};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

   initial begin
      int t0;
      bus.start = 1'b0;
      bus.train = 1'b0;
      bus.abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", outs(), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      sync(t0);
      push_fwd(t0, 4);
      push(t0 + 17, 4'b0, 4'b0, 1'b1, 1'b0, 2'd3, 1'b0);
      pulse(1'b0);
      chk("fwd_busy_t1", bus.busy, 1);
      wait_to(t0 + 17);
      chk("fwd_busy_t17", bus.busy, 1);
      wait_to(t0 + 18);
      chk("fwd_busy_t18", bus.busy, 0);
      chk("fwd_error", bus.error, 0);
      repeat (3) @(negedge clk);
      end_check("fwd_queue");

      sync(t0);
      push_fwd(t0, 4);
      push_bk(t0, 4);
      push(t0 + 33, 4'b0, 4'b0, 1'b1, 1'b0, 2'd0, 1'b0);
      pulse(1'b1);
      wait_to(t0 + 24);
      chk("train_bkphase_t24", bus.bk_phase, 1);
      wait_to(t0 + 32);
      chk("train_bkphase_t32", bus.bk_phase, 1);
      wait_to(t0 + 34);
      chk("train_busy_t34", bus.busy, 0);
      chk("train_bkphase_t34", bus.bk_phase, 0);
      repeat (3) @(negedge clk);
      end_check("train_queue");

      fmute = 4'b0100;
      sync(t0);
      push_fwd(t0, 3);
      push(t0 + 18, 4'b0, 4'b0, 1'b1, 1'b1, 2'd2, 1'b0);
      pulse(1'b0);
      wait_to(t0 + 19);
      chk("tmo_error", bus.error, 1);
      chk("tmo_busy", bus.busy, 0);
      chk("tmo_idx", bus.layer_idx, 2);
      repeat (4) @(negedge clk);
      chk("tmo_error_sticky", bus.error, 1);
      end_check("tmo_queue");
      fmute = 4'b0000;

      sync(t0);
      push_fwd(t0, 4);
      push(t0 + 17, 4'b0, 4'b0, 1'b1, 1'b0, 2'd3, 1'b0);
      pulse(1'b0);
      chk("tmo_error_cleared", bus.error, 0);
      wait_to(t0 + 20);
      end_check("after_tmo_queue");

      inj_en = 1'b1;
      sync(t0);
      push_fwd(t0, 4);
      push(t0 + 17, 4'b0, 4'b0, 1'b1, 1'b0, 2'd3, 1'b0);
      pulse(1'b0);
      wait_to(t0 + 8);
      chk("early_done_idx", bus.layer_idx, 1);
      wait_to(t0 + 20);
      inj_en = 1'b0;
      end_check("early_done_queue");

      sync(t0);
      push_fwd(t0, 4);
      push_bk(t0, 2);
      pulse(1'b1);
      wait_to(t0 + 23);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("abort_busy", bus.busy, 0);
      chk("abort_bkphase", bus.bk_phase, 0);
      repeat (6) @(negedge clk);
      end_check("abort_queue");

      sync(t0);
      push_fwd(t0, 4);
      push(t0 + 17, 4'b0, 4'b0, 1'b1, 1'b0, 2'd3, 1'b0);
      pulse(1'b0);
      wait_to(t0 + 20);
      end_check("after_abort_queue");

      sync(t0);
      push_fwd(t0, 2);
      pulse(1'b0);
      wait_to(t0 + 6);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", outs(), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      end_check("reset_queue");

      sync(t0);
      push_fwd(t0, 4);
      push_bk(t0, 4);
      push(t0 + 33, 4'b0, 4'b0, 1'b1, 1'b0, 2'd0, 1'b0);
      pulse(1'b1);
      wait_to(t0 + 36);
      end_check("after_reset_queue");

      sync(t0);
      push_fwd(t0, 4);
      push(t0 + 17, 4'b0, 4'b0, 1'b1, 1'b0, 2'd3, 1'b0);
      pulse(1'b0);
      wait_to(t0 + 7);
      bus.start = 1'b1;
      bus.train = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.train = 1'b0;
      chk("ignored_start_idx", bus.layer_idx, 1);
      wait_to(t0 + 22);
      chk("ignored_start_busy", bus.busy, 0);
      end_check("ignored_start_queue");

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Sequences forward and backward propagation through a chain of NUM_LAYERS trit-layer stages (down/unit layers). Each stage exposes a fd_prop/bk_prop start pulse and a fd_prop_done/bk_prop_done completion pulse.
- Runs a forward pass layer 0 to NUM_LAYERS-1. When training, it then runs a backward pass NUM_LAYERS-1 down to 0.
- Includes a per-layer timeout watchdog and a start/busy/done handshake to the top-level training controller.

Parameters:
- NUM_LAYERS, 4, number of layers in the chain (1..16)
- TIMEOUT, 255, max cycles to wait for a layer's done pulse before erroring (1..65535)
- IDX_W, $clog2(NUM_LAYERS) min 1, width of layer_idx

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- start  input  1  begin a pass; sampled only in IDLE
- train  input  1  sampled with start: 1 = forward then backward, 0 = forward only
- abort  input  1  return to IDLE immediately; no done pulse
- fd_prop_done  input  NUM_LAYERS  per-layer forward completion pulses
- bk_prop_done  input  NUM_LAYERS  per-layer backward completion pulses
- fd_prop  output  NUM_LAYERS  one-hot, 1-cycle forward start pulses
- bk_prop  output  NUM_LAYERS  one-hot, 1-cycle backward start pulses
- busy  output  1  high from the cycle after start acceptance until done
- done  output  1  1-cycle pulse at end of pass (success or error)
- error  output  1  timeout flag; sticky until next accepted start
- layer_idx  output  IDX_W  layer currently issued or awaited
- bk_phase  output  1  1 while in backward states

Behaviour:
- Reset (rst_in=0, async): state=IDLE. All outputs 0. Timeout counter 0. Latched train bit 0. Reset mid-pass aborts with no done pulse.
- States: IDLE, FWD_ISSUE, FWD_WAIT, BK_ISSUE, BK_WAIT, FINISH.
- IDLE:
  - start=1 at cycle t: latch train, clear error, layer_idx=0, go to FWD_ISSUE.
  - busy=1 from t+1.
- FWD_ISSUE (one cycle):
  - fd_prop[layer_idx]=1, all other bits 0.
  - Clear timeout counter; go to FWD_WAIT.
  - First fd_prop pulse therefore appears at t+1.
- FWD_WAIT:
  - Only fd_prop_done[layer_idx] is honoured. Other done bits and any bk_prop_done are ignored.
  - On done at cycle d: if layer_idx<NUM_LAYERS-1, increment layer_idx and go to FWD_ISSUE, so the next fd_prop is at d+1.
  - On done for the last layer: if train, go to BK_ISSUE with layer_idx unchanged (NUM_LAYERS-1); otherwise go to FINISH.
- BK_ISSUE / BK_WAIT:
  - Mirror the forward states using bk_prop/bk_prop_done. bk_phase=1.
  - After layer 0's done, go to FINISH. Otherwise decrement layer_idx.
- Done pulses are sampled only in WAIT states. A done asserted during an ISSUE cycle is ignored, because layers have at least 1 cycle of latency.
- Timeout:
  - Counter increments each WAIT cycle without a matching done.
  - If it reaches TIMEOUT, set error=1 and go to FINISH. layer_idx keeps the failing layer.
  - A done in the same cycle the counter reaches TIMEOUT counts as success (done wins).
- FINISH (one cycle): done=1. Next cycle: busy=0, state=IDLE.
- Any 1-cycle start→accept path is therefore at least 2·NUM_LAYERS+1 cycles long for forward-only.
- abort=1 in any non-IDLE state: next state IDLE; busy=0; no done; error unchanged; no further prop pulses.
- abort has priority over done and timeout.
- start while busy is ignored. start and abort together in IDLE: abort wins (stay IDLE).
- fd_prop and bk_prop are never both nonzero. At most one bit is set in the union.
- error stays readable after done until the next accepted start.
- NUM_LAYERS=1: forward = one issue/wait. The backward pass reuses layer 0.

Test Plan:
- Forward pass, NUM_LAYERS=4, train=0: start at cycle 0; each layer answers with done 3 cycles after its fd_prop. Required: fd_prop=0001 at cycle 1, 0010 at 5, 0100 at 9, 1000 at 13; done at 17; busy=0 at 18; error=0; bk_prop never set.
- Train pass, same stimulus with train=1: after fd_prop=1000 and its done, bk_prop=1000, 0100, 0010, 0001 at 4-cycle spacing; bk_phase=1 throughout the backward pass; single done pulse at the end.
- Timeout, TIMEOUT=8: layer 2 never answers. Required: error=1 and done pulse 8 cycles after entering FWD_WAIT for layer 2; layer_idx=2; no fd_prop[3]. A later start clears error.
- Wrong-index/early done: drive fd_prop_done=1111 during every ISSUE cycle and fd_prop_done[3] while awaiting layer 1. Required: neither advances the sequence; only fd_prop_done[1] in WAIT does.
- Abort and reset mid-pass:
  - abort during BK_WAIT for layer 2: IDLE next cycle, busy=0, no done.
  - rst_in low mid-FWD_WAIT: all outputs 0 immediately (asynchronously).
  - A new start after either runs a clean pass.
- Ignored start: pulse start during FWD_WAIT. Required: no restart and no change to layer_idx; the sequence completes normally.
